ppu_ram_responder: RTL and testbench
====================================

# ppu_ram_responder

Memory-side responder for the PPU's 4-pin serial RAM interface: deserializes nibble-serial word addresses driven by the PPU on its address pins, reads a 16-bit word from an internal RAM, and serializes it back nibble by nibble on the pins the PPU samples as data. It is the far end of the PPU↔RAM link, used as the RAM model in simulation and as the RAM front end on FPGA builds. A host-side write port loads tile, map, sprite and palette content.

## Interface
- `ADDR_BITS`, 10: word address width; RAM depth is 2^ADDR_BITS 16-bit words.
- `LATENCY`, 0: extra cycles inserted between address completion and first data nibble; legal range 0..7.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `addr_pins` in 4: address nibble from PPU, one per cycle.
- `data_pins` out 4: data nibble to PPU, registered.
- `resync` in 1: the current cycle is address nibble 0.
- `wr_en` in 1: host write strobe.
- `wr_addr` in ADDR_BITS: host write word address.
- `wr_data` in 16: host write data.
- `phase` out 2: index of the address nibble sampled this cycle.
- `oob_error` out 1: sticky out-of-range flag (present only with macro, see Configuration).

## Operation
- Frames: 4 cycles, phase 0..3, one address nibble per phase, least significant nibble first; 16-bit frame address = {n3,n2,n1,n0}.
- Phase counter: 0 in first cycle after reset, increments mod 4 every cycle; `resync` high forces this cycle to phase 0 (counter continues 1,2,3 after it). Resync discards any partially assembled address; words already read continue to be shifted out.
- Frames are back to back; the PPU issues a new address every frame. No idle encoding: every completed frame is a read.
- Read: at the end of phase 3, the assembled address is registered; RAM is read the next cycle using address bits [ADDR_BITS-1:0] (upper bits per Configuration).
- Output: the read word passes through an LATENCY-stage delay line, then loads a 16-bit shift register; `data_pins` presents nibbles 0,1,2,3 (LSB first) on 4 consecutive cycles. Consecutive words abut with no gap.
- `data_pins` outputs 0 whenever no word is being shifted out (after reset, before first word).
- Host write: `wr_en` writes `wr_data` to `wr_addr` at the clock edge; independent of phase; one write per cycle max.

## Timing
- Reset values: `data_pins`=0, `phase`=0, `oob_error`=0, shift register and delay line cleared (in-flight words dropped).
- Address nibbles at cycles c..c+3 (phase 0..3) → data nibble 0 on `data_pins` in cycle c+5+LATENCY, nibble 3 in cycle c+8+LATENCY.
- LATENCY=0: throughput one word per 4 cycles, output continuous.
- Read/write collision: RAM read occurs in cycle c+4. A write with `wr_en` in cycle ≤ c+3 is visible; a write in cycle c+4 to the same address is not (read-before-write); the old word is returned.
- Reset mid-frame: partial address discarded; next cycle is phase 0.
- `resync` during phase 3 of a frame: that frame is not read.

## Configuration
- `PPU_RAM_RESP_BOUNDS_CHECK_EN` defined: a frame address with any of bits [15:ADDR_BITS] set reads as 16'h0000 and sets `oob_error` (sticky until `reset`); `oob_error` port exists.
- Not defined: upper address bits ignored (address wraps modulo 2^ADDR_BITS); no `oob_error` port, no flag logic.

## Test plan
- Write 16'hBEEF at 0x012, drive nibbles 2,1,0,0 from phase 0 in cycle 10, LATENCY=0 → `data_pins` = F,E,E,B in cycles 15..18.
- Back-to-back frames for 0x000..0x007 preloaded with address+0x1000 → continuous 32-cycle nibble stream, no gaps, correct order.
- LATENCY=3, same as first scenario → nibbles appear cycles 18..21.
- Write 0x012=16'h1111 in cycle c+4 of a read of 0x012 holding 16'h2222 → returns 16'h2222; repeat read next frame → 16'h1111.
- Assert `resync` mid-frame at phase 2, then drive full address → data matches new address; reset mid-output → `data_pins`=0 next cycle, `phase`=0.
- Macro on, ADDR_BITS=10, address 0x0400 → data 0, `oob_error`=1 until reset; macro off → returns word at 0x000.

Source files
------------

// File: rtl/ppu_ram_responder.sv
// ppu_ram_responder: nibble-serial RAM responder for the PPU link; assembles 4-nibble addresses and streams 16-bit words back LSB nibble first.
// Optional PPU_RAM_RESP_BOUNDS_CHECK_EN: out-of-range addresses read as zero and raise a sticky oob_error.
module ppu_ram_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           addr_pins,
    output logic [3:0]           data_pins,
    input  logic                 resync,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [15:0]          wr_data,
`ifdef PPU_RAM_RESP_BOUNDS_CHECK_EN
    output logic                 oob_error,
`endif
    output logic [1:0]           phase
);
    logic [1:0]  phase_q, phase_d;
    logic [11:0] acc_q, acc_d;
    logic [15:0] addr_q, addr_d;
    logic        rd_v_q, rd_v_d;
    logic [15:0] mem_q [2**ADDR_BITS];
    logic [15:0] rd_word;
    logic [16:0] tail;
    logic [3:0]  data_q, data_d;
    logic [11:0] rest_q, rest_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        phase   = resync ? 2'd0 : phase_q;
        phase_d = phase + 2'd1;
        acc_d   = {phase == 2'd2 ? addr_pins : acc_q[11:8],
                   phase == 2'd1 ? addr_pins : acc_q[7:4],
                   phase == 2'd0 ? addr_pins : acc_q[3:0]};
        rd_v_d  = phase == 2'd3;
        addr_d  = rd_v_d ? {addr_pins, acc_q} : addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 2'd0;
            acc_q   <= 12'd0;
            addr_q  <= 16'd0;
            rd_v_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            rd_v_q  <= rd_v_d;
        end
    end

    // Read-before-write: the combinational read sees the old word on a same-cycle write.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

`ifdef PPU_RAM_RESP_BOUNDS_CHECK_EN
    logic oob, oob_q;
    assign oob       = (addr_q >> ADDR_BITS) != 16'd0;
    assign rd_word   = oob ? 16'd0 : mem_q[addr_q[ADDR_BITS-1:0]];
    assign oob_error = oob_q;
    always_ff @(posedge clk) begin
        if (reset) oob_q <= 1'b0;
        else if (rd_v_q && oob) oob_q <= 1'b1;
    end
`else
    assign rd_word = mem_q[addr_q[ADDR_BITS-1:0]];
`endif

    generate
        if (LATENCY == 0) begin : g_nodl
            assign tail = {rd_v_q, rd_word};
        end else begin : g_dl
            logic [16:0] dl_q [LATENCY];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) dl_q[i] <= 17'd0;
                end else begin
                    dl_q[0] <= {rd_v_q, rd_word};
                    for (int i = 1; i < LATENCY; i++) dl_q[i] <= dl_q[i-1];
                end
            end
            assign tail = dl_q[LATENCY-1];
        end
    endgenerate

    always_comb begin
        data_d = tail[16] ? tail[3:0] : cnt_q != 2'd0 ? rest_q[3:0] : 4'd0;
        rest_d = tail[16] ? tail[15:4] : {4'd0, rest_q[11:4]};
        cnt_d  = tail[16] ? 2'd3 : cnt_q != 2'd0 ? cnt_q - 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= 4'd0;
            rest_q <= 12'd0;
            cnt_q  <= 2'd0;
        end else begin
            data_q <= data_d;
            rest_q <= rest_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_pins = data_q;
endmodule

// File: tb/tb_ppu_ram_responder.sv
// tb_ppu_ram_responder: scoreboard bench driving two responders (LATENCY 0 and 3) with shared stimulus.
module tb_ppu_ram_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  addr_pins = 4'd0;
    logic        resync = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = 10'd0;
    logic [15:0] wr_data = 16'd0;
    logic [3:0]  d0, d3;
    logic [1:0]  ph0, ph3;
    logic        oob0, oob3;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {int c; logic [3:0] n;} exp_t;
    exp_t q0[$], q3[$];
    logic [15:0] mem [1024];
    logic [1:0]  ph = 2'd0;
    logic [3:0]  nib [3];
    logic        pend = 1'b0;
    logic [15:0] pa;
    logic        oob_exp = 1'b0;

    ppu_ram_responder #(.ADDR_BITS(10), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .addr_pins(addr_pins), .data_pins(d0), .resync(resync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PPU_RAM_RESP_BOUNDS_CHECK_EN
        .oob_error(oob0),
`endif
        .phase(ph0));
    ppu_ram_responder #(.ADDR_BITS(10), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .addr_pins(addr_pins), .data_pins(d3), .resync(resync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PPU_RAM_RESP_BOUNDS_CHECK_EN
        .oob_error(oob3),
`endif
        .phase(ph3));
`ifndef PPU_RAM_RESP_BOUNDS_CHECK_EN
    assign oob0 = 1'b0;
    assign oob3 = 1'b0;
`endif

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: a read happens the cycle after phase 3 and sees writes up to that frame's phase 3.
    always @(posedge clk) begin
        logic [1:0] cur;
        logic [15:0] w;
        cur = resync ? 2'd0 : ph;
        if (reset) begin
            ph = 2'd0;
            pend = 1'b0;
            oob_exp = 1'b0;
            q0.delete();
            q3.delete();
        end else begin
            if (pend) begin
                w = mem[pa[9:0]];
`ifdef PPU_RAM_RESP_BOUNDS_CHECK_EN
                if (pa[15:10] != 6'd0) begin
                    w = 16'd0;
                    oob_exp = 1'b1;
                end
`endif
                for (int k = 0; k < 4; k++) begin
                    q0.push_back('{cyc + 1 + k, w[k*4 +: 4]});
                    q3.push_back('{cyc + 4 + k, w[k*4 +: 4]});
                end
            end
            pend = cur == 2'd3;
            if (cur == 2'd3) pa = {addr_pins, nib[2], nib[1], nib[0]};
            else nib[cur] = addr_pins;
            ph = cur + 2'd1;
        end
        if (wr_en) mem[wr_addr] = wr_data;
        cyc++;
    end

    always @(negedge clk) begin
        check("phase0", {14'd0, ph0}, {14'd0, resync ? 2'd0 : ph});
        check("phase3", {14'd0, ph3}, {14'd0, resync ? 2'd0 : ph});
        if (q0.size() > 0 && q0[0].c == cyc) begin
            check("data_lat0", {12'd0, d0}, {12'd0, q0[0].n});
            void'(q0.pop_front());
        end else check("idle_lat0", {12'd0, d0}, 16'd0);
        if (q3.size() > 0 && q3[0].c == cyc) begin
            check("data_lat3", {12'd0, d3}, {12'd0, q3[0].n});
            void'(q3.pop_front());
        end else check("idle_lat3", {12'd0, d3}, 16'd0);
`ifdef PPU_RAM_RESP_BOUNDS_CHECK_EN
        check("oob0", {15'd0, oob0}, {15'd0, oob_exp});
        check("oob3", {15'd0, oob3}, {15'd0, oob_exp});
`endif
    end

    task automatic drv(input logic [3:0] n, input logic rs, input logic we,
                       input logic [9:0] wa, input logic [15:0] wd, input logic rst);
        @(posedge clk);
        #1;
        addr_pins = n;
        resync = rs;
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        reset = rst;
    endtask

    task automatic align();
        while (!(reset || (resync ? 2'd0 : ph) == 2'd3)) drv(4'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    endtask

    task automatic frame(input logic [15:0] a, input logic rs, input logic we,
                         input logic [9:0] wa, input logic [15:0] wd, output int c);
        if (!rs) align();
        c = 0;
        for (int k = 0; k < 4; k++) begin
            drv(a[k*4 +: 4], rs && k == 0, we && k == 0, wa, wd, 1'b0);
            if (k == 0) c = cyc;
        end
    endtask

    task automatic partial(input logic [15:0] a, input int n);
        align();
        for (int k = 0; k < n; k++) drv(a[k*4 +: 4], 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(4'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
    endtask

    initial begin
        int c0;
        logic [15:0] beef;
        beef = 16'hBEEF;
        repeat (3) drv(4'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        for (int i = 0; i < 1024; i++)
            drv(4'd0, 1'b0, 1'b1, 10'(i), i < 8 ? 16'(i) + 16'h1000 : 16'($urandom), 1'b0);
        drv(4'd0, 1'b0, 1'b1, 10'h012, 16'hBEEF, 1'b0);
        frame(16'h0012, 1'b0, 1'b0, 10'd0, 16'd0, c0);
        addr_pins = 4'd0;
        while (cyc < c0 + 5) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            if (k < 4) check("beef_lat0", {12'd0, d0}, {12'd0, beef[k*4 +: 4]});
            if (k >= 3) check("beef_lat3", {12'd0, d3}, {12'd0, beef[(k-3)*4 +: 4]});
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) frame(16'(i), 1'b0, 1'b0, 10'd0, 16'd0, c0);
        drv(4'd0, 1'b0, 1'b1, 10'h012, 16'h2222, 1'b0);
        frame(16'h0012, 1'b0, 1'b0, 10'd0, 16'd0, c0);
        frame(16'h0012, 1'b0, 1'b1, 10'h012, 16'h1111, c0);
        frame(16'h0012, 1'b0, 1'b0, 10'd0, 16'd0, c0);
        partial(16'h03AB, 2);
        frame(16'h0005, 1'b1, 1'b0, 10'd0, 16'd0, c0);
        partial(16'h03AB, 3);
        frame(16'h0006, 1'b1, 1'b0, 10'd0, 16'd0, c0);
        frame(16'h0003, 1'b0, 1'b0, 10'd0, 16'd0, c0);
        idle(2);
        drv(4'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        idle(3);
        frame(16'h0400, 1'b0, 1'b0, 10'd0, 16'd0, c0);
        idle(12);
        drv(4'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        idle(4);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
